// File: rtl/ball_frame_pkg.sv
// Shared widths, slot-count default and FSM states for the ball frame collector.
package ball_frame_pkg;

   localparam int DEF_MAX_BALLS = 7;
   localparam int X_W           = 11;
   localparam int Y_W           = 10;
   localparam int CNT_W         = 3;

   typedef enum logic [1:0] {
      COLLECT,
      PAD,
      EMIT,
      WAIT_EVAL
   } state_t;

endpackage

// File: rtl/ball_slot_array.sv
// Slot storage for one frame: append or ordered insert, then pad fill.
// BALL_SORT_EN keeps slots 0..count-1 in ascending, stable x order.
module ball_slot_array
   import ball_frame_pkg::*;
#(
   parameter int MAX_BALLS = DEF_MAX_BALLS,
   parameter int PAD_X     = 0,
   parameter int PAD_Y     = 0
) (
   input  logic                               clk_in,
   input  logic                               rst_in,
   input  logic                               store_in,
   input  logic                               pad_in,
   input  logic [CNT_W-1:0]                   count_in,
   input  logic [X_W-1:0]                     x_in,
   input  logic [Y_W-1:0]                     y_in,
   output logic [MAX_BALLS-1:0][X_W-1:0]      x_out,
   output logic [MAX_BALLS-1:0][Y_W-1:0]      y_out
);

   logic [MAX_BALLS-1:0][X_W-1:0] x_q, x_d, x_sh;
   logic [MAX_BALLS-1:0][Y_W-1:0] y_q, y_d, y_sh;
   logic [MAX_BALLS-1:0]          le, prev_le;

   // le marks stored entries that stay ahead of the new centroid
   always_comb begin
      le = '0;
      for (int i = 0; i < MAX_BALLS; i++)
         le[i] = (i < int'(count_in)) && (x_q[i] <= x_in);
      prev_le = {le[MAX_BALLS-2:0], 1'b1};
      x_sh    = {x_q[MAX_BALLS-2:0], {X_W{1'b0}}};
      y_sh    = {y_q[MAX_BALLS-2:0], {Y_W{1'b0}}};
   end

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (pad_in) begin
         for (int i = 0; i < MAX_BALLS; i++) begin
            if (i >= int'(count_in)) begin
               x_d[i] = X_W'(PAD_X);
               y_d[i] = Y_W'(PAD_Y);
            end
         end
      end else if (store_in) begin
         for (int i = 0; i < MAX_BALLS; i++) begin
`ifdef BALL_SORT_EN
            if (i <= int'(count_in) && !le[i]) begin
               if (prev_le[i]) begin
                  x_d[i] = x_in;
                  y_d[i] = y_in;
               end else begin
                  x_d[i] = x_sh[i];
                  y_d[i] = y_sh[i];
               end
            end
`else
            if (i == int'(count_in)) begin
               x_d[i] = x_in;
               y_d[i] = y_in;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         x_q <= {MAX_BALLS{X_W'(PAD_X)}};
         y_q <= {MAX_BALLS{Y_W'(PAD_Y)}};
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_out = x_q;
   assign y_out = y_q;

endmodule

// File: rtl/ball_frame_collector.sv
// Collects ball centroids into a fixed slot frame and hands it to an evaluator.
// Define BALL_SORT_EN to store slots in ascending x order.
module ball_frame_collector
   import ball_frame_pkg::*;
#(
   parameter int MAX_BALLS = DEF_MAX_BALLS,
   parameter int PAD_X     = 0,
   parameter int PAD_Y     = 0
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          centroid_valid_in,
   input  logic [X_W-1:0]                centroid_x_in,
   input  logic [Y_W-1:0]                centroid_y_in,
   input  logic                          frame_end_in,
   output logic                          centroid_ready_out,
   input  logic [CNT_W-1:0]              num_balls_in,
   input  logic                          eval_done_in,
   output logic                          data_valid_out,
   output logic [MAX_BALLS-1:0][X_W-1:0] real_balls_x_out,
   output logic [MAX_BALLS-1:0][Y_W-1:0] real_balls_y_out,
   output logic [CNT_W-1:0]              count_out,
   output logic                          overflow_out
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, num_q, num_clamp, num_eff;
   logic             num_vld_q, ovf_q;
   logic             acc, fe_acc, store, drop, pad_en;

   assign acc       = centroid_valid_in && centroid_ready_out;
   assign fe_acc    = frame_end_in && centroid_ready_out;
   assign num_clamp = (num_balls_in > CNT_W'(MAX_BALLS)) ?
                      CNT_W'(MAX_BALLS) : num_balls_in;
   // the first accepted beat of a frame uses the live count directly
   assign num_eff   = num_vld_q ? num_q : num_clamp;
   assign store     = acc && (count_q < num_eff);
   assign drop      = acc && !store;

   always_ff @(posedge clk_in) begin
      if (!rst_in) state_q <= COLLECT;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         COLLECT:   if (fe_acc) state_d = PAD;
         PAD:       state_d = EMIT;
         EMIT:      state_d = WAIT_EVAL;
         WAIT_EVAL: if (eval_done_in) state_d = COLLECT;
         default:   state_d = COLLECT;
      endcase
   end

   always_comb begin
      centroid_ready_out = (state_q == COLLECT);
      data_valid_out     = (state_q == EMIT);
      pad_en             = (state_q == PAD);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         count_q   <= '0;
         num_q     <= '0;
         num_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (state_q == WAIT_EVAL && eval_done_in) begin
         count_q   <= '0;
         num_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         if ((acc || fe_acc) && !num_vld_q) begin
            num_q     <= num_clamp;
            num_vld_q <= 1'b1;
         end
         if (store) count_q <= count_q + 1'b1;
         if (drop)  ovf_q   <= 1'b1;
      end
   end

   ball_slot_array #(
      .MAX_BALLS (MAX_BALLS),
      .PAD_X     (PAD_X),
      .PAD_Y     (PAD_Y)
   ) u_slots (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .store_in (store),
      .pad_in   (pad_en),
      .count_in (count_q),
      .x_in     (centroid_x_in),
      .y_in     (centroid_y_in),
      .x_out    (real_balls_x_out),
      .y_out    (real_balls_y_out)
   );

   assign count_out    = count_q;
   assign overflow_out = ovf_q;

endmodule

// File: tb/tb_ball_frame_collector.sv
// Scoreboard bench for ball_frame_collector; expectations follow BALL_SORT_EN.
module tb_ball_frame_collector;

   logic                 clk_in = 1'b0;
   logic                 rst_in;
   logic                 centroid_valid_in;
   logic [10:0]          centroid_x_in;
   logic [9:0]           centroid_y_in;
   logic                 frame_end_in;
   logic                 centroid_ready_out;
   logic [2:0]           num_balls_in;
   logic                 eval_done_in;
   logic                 data_valid_out;
   logic [6:0][10:0]     real_balls_x_out;
   logic [6:0][9:0]      real_balls_y_out;
   logic [2:0]           count_out;
   logic                 overflow_out;

   typedef struct {
      logic [6:0][10:0] x;
      logic [6:0][9:0]  y;
      logic [2:0]       cnt;
      logic             ovf;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_dv = 1'b0;

   ball_frame_collector dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .centroid_valid_in  (centroid_valid_in),
      .centroid_x_in      (centroid_x_in),
      .centroid_y_in      (centroid_y_in),
      .frame_end_in       (frame_end_in),
      .centroid_ready_out (centroid_ready_out),
      .num_balls_in       (num_balls_in),
      .eval_done_in       (eval_done_in),
      .data_valid_out     (data_valid_out),
      .real_balls_x_out   (real_balls_x_out),
      .real_balls_y_out   (real_balls_y_out),
      .count_out          (count_out),
      .overflow_out       (overflow_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string nm, input logic [127:0] got,
                      input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   // monitor: every data_valid_out pulse pops one expected frame
   always @(negedge clk_in) begin
      if (data_valid_out) begin
         chk("dv_single_cycle", {127'd0, prev_dv}, 128'd0);
         if (q.size() == 0) begin
            chk("dv_unexpected", 128'd1, 128'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("frame_x",   128'(real_balls_x_out), 128'(e.x));
            chk("frame_y",   128'(real_balls_y_out), 128'(e.y));
            chk("frame_cnt", 128'(count_out),        128'(e.cnt));
            chk("frame_ovf", 128'(overflow_out),     128'(e.ovf));
         end
      end
      prev_dv = data_valid_out;
   end

   function automatic exp_t blank();
      exp_t e;
      e.x = '0;
      e.y = '0;
      e.cnt = '0;
      e.ovf = 1'b0;
      return e;
   endfunction

   task automatic send(input logic [10:0] x, input logic [9:0] y,
                       input logic v, input logic fe);
      chk("ready_before_send", 128'(centroid_ready_out), 128'd1);
      centroid_valid_in = v;
      centroid_x_in     = x;
      centroid_y_in     = y;
      frame_end_in      = fe;
      @(posedge clk_in);
      #1;
      centroid_valid_in = 1'b0;
      frame_end_in      = 1'b0;
   endtask

   task automatic wait_dv();
      int n = 0;
      do begin
         @(posedge clk_in);
         #1;
         n++;
      end while (!data_valid_out && n < 10);
      chk("dv_latency", 128'(n), 128'd1);
   endtask

   task automatic eval(input int hold);
      logic [6:0][10:0] sx;
      logic [6:0][9:0]  sy;
      logic [3:0]       sc;
      sx = real_balls_x_out;
      sy = real_balls_y_out;
      sc = {count_out, overflow_out};
      if (hold == 0) begin
         eval_done_in = 1'b1;
         @(posedge clk_in);
         #1;
         chk("eval_ignored_in_emit", 128'(centroid_ready_out), 128'd0);
      end else begin
         @(posedge clk_in);
         #1;
         repeat (hold) begin
            @(posedge clk_in);
            #1;
            chk("hold_ready", 128'(centroid_ready_out), 128'd0);
            chk("hold_stable",
                {real_balls_x_out, real_balls_y_out, count_out, overflow_out},
                {sx, sy, sc});
         end
         eval_done_in = 1'b1;
      end
      @(posedge clk_in);
      #1;
      eval_done_in = 1'b0;
      chk("ready_after_eval", 128'(centroid_ready_out), 128'd1);
   endtask

   initial begin
      exp_t e;
      rst_in            = 1'b0;
      centroid_valid_in = 1'b0;
      centroid_x_in     = '0;
      centroid_y_in     = '0;
      frame_end_in      = 1'b0;
      num_balls_in      = 3'd0;
      eval_done_in      = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_dv",    128'(data_valid_out), 128'd0);
      chk("rst_cnt",   128'(count_out),      128'd0);
      chk("rst_ovf",   128'(overflow_out),   128'd0);
      chk("rst_slots", {real_balls_x_out, real_balls_y_out}, 128'd0);
      rst_in = 1'b1;

      // num latched on first beat; later num changes must not matter
      num_balls_in = 3'd3;
      e = blank();
`ifdef BALL_SORT_EN
      e.x[0] = 20;  e.y[0] = 60;
      e.x[1] = 100; e.y[1] = 50;
`else
      e.x[0] = 100; e.y[0] = 50;
      e.x[1] = 20;  e.y[1] = 60;
`endif
      e.x[2] = 300; e.y[2] = 70;
      e.cnt = 3;
      q.push_back(e);
      send(11'd100, 10'd50, 1'b1, 1'b0);
      num_balls_in = 3'd1;
      send(11'd20, 10'd60, 1'b1, 1'b0);
      send(11'd300, 10'd70, 1'b1, 1'b0);
      send(11'd0, 10'd0, 1'b0, 1'b1);
      wait_dv();
      eval(0);

      // overflow: only the first two kept
      num_balls_in = 3'd2;
      e = blank();
`ifdef BALL_SORT_EN
      e.x[0] = 3; e.y[0] = 2;
      e.x[1] = 9; e.y[1] = 1;
`else
      e.x[0] = 9; e.y[0] = 1;
      e.x[1] = 3; e.y[1] = 2;
`endif
      e.cnt = 2;
      e.ovf = 1'b1;
      q.push_back(e);
      send(11'd9, 10'd1, 1'b1, 1'b0);
      send(11'd3, 10'd2, 1'b1, 1'b0);
      send(11'd7, 10'd3, 1'b1, 1'b0);
      send(11'd8, 10'd4, 1'b1, 1'b0);
      send(11'd0, 10'd0, 1'b0, 1'b1);
      wait_dv();
      eval(0);

      // empty frame
      q.push_back(blank());
      send(11'd0, 10'd0, 1'b0, 1'b1);
      wait_dv();
      eval(0);

      // beat with frame_end on the same edge, evaluator stalls 10 cycles
      num_balls_in = 3'd2;
      e = blank();
`ifdef BALL_SORT_EN
      e.x[0] = 40; e.y[0] = 6;
      e.x[1] = 50; e.y[1] = 5;
`else
      e.x[0] = 50; e.y[0] = 5;
      e.x[1] = 40; e.y[1] = 6;
`endif
      e.cnt = 2;
      q.push_back(e);
      send(11'd50, 10'd5, 1'b1, 1'b0);
      send(11'd40, 10'd6, 1'b1, 1'b1);
      wait_dv();
      eval(10);

      // equal x keeps arrival order
      num_balls_in = 3'd7;
      e = blank();
`ifdef BALL_SORT_EN
      e.x[0] = 5;  e.y[0] = 3;
      e.x[1] = 10; e.y[1] = 1;
      e.x[2] = 10; e.y[2] = 2;
`else
      e.x[0] = 10; e.y[0] = 1;
      e.x[1] = 10; e.y[1] = 2;
      e.x[2] = 5;  e.y[2] = 3;
`endif
      e.cnt = 3;
      q.push_back(e);
      send(11'd10, 10'd1, 1'b1, 1'b0);
      send(11'd10, 10'd2, 1'b1, 1'b0);
      send(11'd5, 10'd3, 1'b1, 1'b1);
      wait_dv();

      // reset while in WAIT_EVAL
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;
      chk("wrst_ready", 128'(centroid_ready_out), 128'd1);
      chk("wrst_dv",    128'(data_valid_out),     128'd0);
      chk("wrst_cnt",   128'(count_out),          128'd0);
      chk("wrst_slots", {real_balls_x_out, real_balls_y_out}, 128'd0);
      rst_in = 1'b1;

      // partial frame abandoned by reset, next frame clean
      num_balls_in = 3'd1;
      send(11'd99, 10'd9, 1'b1, 1'b0);
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      e = blank();
      e.x[0] = 11;
      e.y[0] = 12;
      e.cnt = 1;
      q.push_back(e);
      send(11'd11, 10'd12, 1'b1, 1'b1);
      wait_dv();
      eval(0);

      repeat (3) @(posedge clk_in);
      #1;
      chk("scoreboard_empty", 128'(q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
